booth_mult_unit: RTL and testbench

//  Sequential signed multiplier (radix-2 Booth) for the multicycle CPU datapath.

---
 rtl/booth_mult_unit.sv | 118 +++++++++++
 tb/tb_booth_mult_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/booth_mult_unit.sv
// Sequential signed radix-2 Booth multiplier for the multicycle CPU MULT path.
// Takes WIDTH edges per product. HI_out/LO_out hold the last completed result.
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   start          multiply request, sampled only while idle
//   A_in, B_in     signed multiplicand / multiplier, captured with start
//   HI_out, LO_out upper / lower half of the 2*WIDTH-bit product (registered)
//   busy           high while a product is running or being reported
//   done           one-cycle pulse when HI_out/LO_out take a new product
module booth_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW = WIDTH + 1;       // accumulator, wide enough for -M of the most negative operand
  localparam int unsigned PW = 2 * WIDTH + 2;   // {acc, mplr, q}

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [AW-1:0]    m_q, m_next;
  logic [PW-1:0]    p_q, p_next;
  logic [CW-1:0]    count_q, count_next;
  logic [WIDTH-1:0] hi_next, lo_next;
  logic             busy_next, done_next;

  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_sum;
  logic [PW-1:0]    p_step;

  // One Booth iteration: add/sub on the {mplr LSB, q} pair, then arithmetic shift right
  always_comb begin
    acc     = p_q[PW-1:WIDTH+1];
    acc_sum = acc;
    unique case (p_q[1:0])
      2'b01:   acc_sum = acc + m_q;
      2'b10:   acc_sum = acc - m_q;
      default: acc_sum = acc;
    endcase
    p_step = {acc_sum[AW-1], acc_sum, p_q[WIDTH:1]};
  end

  // Next-state and next-register values
  always_comb begin
    state_next = state;
    m_next     = m_q;
    p_next     = p_q;
    count_next = count_q;
    hi_next    = HI_out;
    lo_next    = LO_out;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          m_next     = {A_in[WIDTH-1], A_in};
          p_next     = {AW'(0), B_in, 1'b0};
          count_next = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        p_next     = p_step;
        count_next = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          hi_next    = p_step[2*WIDTH:WIDTH+1];
          lo_next    = p_step[WIDTH:1];
          count_next = '0;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    // Status flags are registered from the next state so they line up with it
    busy_next = (state_next != ST_IDLE);
    done_next = (state_next == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      count_q <= '0;
      HI_out  <= '0;
      LO_out  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      m_q     <= m_next;
      p_q     <= p_next;
      count_q <= count_next;
      HI_out  <= hi_next;
      LO_out  <= lo_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed self-checking bench for booth_mult_unit (WIDTH = 32).
// Expected products are hand-computed constants.
module tb_booth_mult_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  booth_mult_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A_in   (A_in),
    .B_in   (B_in),
    .HI_out (HI_out),
    .LO_out (LO_out),
    .busy   (busy),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    end
  endtask

  // One full multiply; optionally pulses start at edges N+5 and N+32 with other operands
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit inject);
    logic [63:0] prev;
    int e;
    @(negedge clk);
    A_in = a; B_in = b; start = 1'b1;
    prev = {HI_out, LO_out};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A_in  = $urandom;
    B_in  = $urandom;
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    e = 0;
    while (done !== 1'b1 && e < 40) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      start = inject && (e == 4 || e == 31);
      if (start) begin
        A_in = 32'd9;
        B_in = 32'd9;
      end
      if (done !== 1'b1 && (e % 8) == 0)
        check($sformatf("%s_hold_e%0d", tag, e), {HI_out, LO_out}, prev);
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(e), 64'd32);
    check({tag, "_product"}, {HI_out, LO_out}, exp);
    check({tag, "_busy_done"}, 64'(busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_no_queue"}, 64'(busy), 64'd0);
    check({tag, "_keep"}, {HI_out, LO_out}, exp);
  endtask

  logic [31:0] ta [3] = '{32'd6, 32'hFFFF_FFFE, 32'h0001_0000};
  logic [31:0] tb [3] = '{32'd7, 32'd100,       32'h0001_0000};
  logic [63:0] te [3] = '{64'h0000_0000_0000_002A,
                          64'hFFFF_FFFF_FFFF_FF38,
                          64'h0000_0001_0000_0000};

  initial begin
    int e;
    reset = 1'b0;
    start = 1'b0;
    A_in  = '0;
    B_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hilo", {HI_out, LO_out}, 64'd0);
    check("rst_flags", {62'd0, busy, done}, 64'd0);
    reset = 1'b1;

    run_op("3x5",   32'd3,         32'd5,         64'h0000_0000_0000_000F, 1'b0);
    run_op("m7x3",  32'hFFFF_FFF9, 32'd3,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_op("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_op("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0);
    run_op("ignore_start", 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, 1'b1);

    // start held high: a new product is accepted two edges after each done
    @(negedge clk);
    start = 1'b1; A_in = ta[0]; B_in = tb[0];
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("held%0d_busy", k), 64'(busy), 64'd1);
      if (k < 2) begin
        A_in = ta[k+1];
        B_in = tb[k+1];
      end else begin
        start = 1'b0;
      end
      e = 0;
      while (done !== 1'b1 && e < 40) begin
        @(posedge clk);
        e++;
        @(negedge clk);
      end
      check($sformatf("held%0d_latency", k), 64'(e), 64'd32);
      check($sformatf("held%0d_product", k), {HI_out, LO_out}, te[k]);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("held%0d_gap", k), 64'(busy), 64'd0);
      if (k < 2) @(posedge clk);
    end

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start = 1'b1; A_in = 32'd1000; B_in = 32'd1000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_hilo", {HI_out, LO_out}, 64'd0);
    check("midrst_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    check("midrst_hold", {HI_out, LO_out}, 64'd0);
    reset = 1'b1;
    run_op("after_rst_2x2", 32'd2, 32'd2, 64'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
